// File: rtl/arb4_rr.sv
// arb4_rr: four-requester round-robin arbiter driving a shared WIDTH-bit write-back mux
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req[3:0]        per-master request lines
//   done            current grantee releases the bus (looked at only while valid=1)
//   d0..d3          source data of masters 0..3
//   gnt[3:0]        registered one-hot grant, zero when idle
//   sel[1:0]        registered index of the current grantee (mux select)
//   valid           registered, high while a grant is active
//   y               d[sel] while valid, else 0
//   timeout         registered one-cycle pulse after a forced release
//
// Build option: define ARB4_TIMEOUT_EN to add the hold-limit counter that forces a
// grant off after MAX_HOLD cycles; otherwise timeout is tied low and MAX_HOLD is unused.
module arb4_rr #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             done,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] y,
    output logic             timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arb4_rr: MAX_HOLD must lie in 2..255");
    end

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [1:0] search_ptr;
    logic [2:0] pick;
    logic       release_ev;
    logic       hold_hit;

    // Returns {found, index}; scanning offsets from 3 down to 0 lets the
    // lowest offset from p (highest priority) overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef ARB4_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
    assign hold_hit = (hold_q == HW'(MAX_HOLD - 1));
    assign timeout  = timeout_q;
`else
    assign hold_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign release_ev = done || !req[sel_q] || hold_hit;
    // On a release the search already uses the rotated pointer, so the
    // releasing master is considered last in the same cycle.
    assign search_ptr = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    assign pick       = rr_pick(search_ptr, req);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
`ifdef ARB4_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        if (state_q == IDLE || release_ev) begin
            if (state_q == GRANT) begin
                ptr_d = sel_q + 2'd1;
`ifdef ARB4_TIMEOUT_EN
                timeout_d = hold_hit && !done;
`endif
            end
            if (pick[2]) begin
                state_d = GRANT;
                sel_d   = pick[1:0];
                gnt_d   = 4'b0001 << pick[1:0];
                valid_d = 1'b1;
`ifdef ARB4_TIMEOUT_EN
                hold_d  = '0;
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        end else begin
`ifdef ARB4_TIMEOUT_EN
            hold_d = hold_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB4_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign y     = !valid_q       ? '0 :
                   sel_q == 2'd0  ? d0 :
                   sel_q == 2'd1  ? d1 :
                   sel_q == 2'd2  ? d2 : d3;
endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: directed self-checking bench for the round-robin arbiter
module tb_arb4_rr;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [7:0] d0 = 8'hA0, d1 = 8'hB1, d2 = 8'hC2, d3 = 8'hD3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] y;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    arb4_rr #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt), .sel(sel), .valid(valid), .y(y), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++;
        if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", y); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        checks++;
        if (sel !== 2'd0 || valid !== 1'b1) begin errors++; $display("FAIL single_sel_valid: got sel=%0d valid=%b expected sel=0 valid=1", sel, valid); end
        checks++;
        if (y !== 8'hA0) begin errors++; $display("FAIL single_y: got %h expected a0", y); end
        req = 4'b0000;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || y !== 8'h00) begin errors++; $display("FAIL single_release: got gnt=%b valid=%b y=%h expected 0000 0 00", gnt, valid, y); end
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL single_ptr_after: got %b expected 0010", gnt); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL contention_first: got %b expected 0001", gnt); end
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== exp_seq[i] || valid !== 1'b1) begin errors++; $display("FAIL contention_step%0d: got gnt=%b valid=%b expected %b 1", i, gnt, valid, exp_seq[i]); end
        end
        done = 1'b0;
        req = 4'b0000;
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL contention_idle: got valid=%b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_m1: got %b expected 0010", gnt); end
        req = 4'b1010;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || y !== 8'hD3) begin errors++; $display("FAIL b2b_handoff: got gnt=%b sel=%0d y=%h expected 1000 3 d3", gnt, sel, y); end
        tick();
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL b2b_hold: got %b expected 1000", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || y !== 8'hB1) begin errors++; $display("FAIL b2b_regrant_m1: got gnt=%b sel=%0d y=%h expected 0010 1 b1", gnt, sel, y); end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || y !== 8'hC2) begin errors++; $display("FAIL withdraw_grant: got gnt=%b y=%h expected 0100 c2", gnt, y); end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got gnt=%b valid=%b expected 0000 0", gnt, valid); end
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL withdraw_ptr: got %b expected 1000", gnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_first: got gnt=%b timeout=%b expected 0001 0", gnt, timeout); end
`ifdef ARB4_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_hold%0d: got gnt=%b timeout=%b expected 0001 0", i, gnt, timeout); end
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_forced: got gnt=%b timeout=%b expected 0100 1", gnt, timeout); end
        tick();
        checks++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse_end: got gnt=%b timeout=%b expected 0100 0", gnt, timeout); end
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL notimeout_hold%0d: got gnt=%b timeout=%b expected 0001 0", i, gnt, timeout); end
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL rstmid_grant: got %b expected 0100", gnt); end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        rst = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got gnt=%b sel=%0d valid=%b timeout=%b expected 0000 0 0 0", gnt, sel, valid, timeout); end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b expected 0001", gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_withdraw();
        test_timeout();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
